// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU function codes,
// controller states, flag bit positions and a small decode helper.
package alu_cmd_sequencer_pkg;

   // ALU function codes understood by the external 4-bit ALU
   localparam logic [3:0] F_ADD  = 4'b0000;
   localparam logic [3:0] F_SUB  = 4'b0001;
   localparam logic [3:0] F_AND  = 4'b0100;
   localparam logic [3:0] F_OR   = 4'b0101;
   localparam logic [3:0] F_XOR  = 4'b0110;
   localparam logic [3:0] F_SLL  = 4'b1000;
   localparam logic [3:0] F_SRL  = 4'b1001;
   localparam logic [3:0] F_SRA  = 4'b1010;
   localparam logic [3:0] F_PASS = 4'b1111;

   // Positions inside the {Z,N,C,V} flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      LOAD = 2'd2,
      RESP = 2'd3
   } seq_state_t;

   // Only add and subtract produce meaningful carry/overflow flags
   function automatic logic is_arith(input logic [3:0] func);
      return (func == F_ADD) || (func == F_SUB);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a host and the ALU command
// sequencer. The master drives commands and consumes responses.
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [3:0]       cmd_func;
   logic [WIDTH-1:0] cmd_operand;
   logic [CNT_W-1:0] cmd_count;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_acc;
   logic [3:0]       rsp_flags;

   modport master (
      output cmd_valid, cmd_load, cmd_func, cmd_operand, cmd_count, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_acc, rsp_flags
   );

   modport slave (
      input  cmd_valid, cmd_load, cmd_func, cmd_operand, cmd_count, rsp_ready,
      output cmd_ready, rsp_valid, rsp_acc, rsp_flags
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-machine controller around an external combinational ALU.
// A command either loads the accumulator directly or iterates one ALU
// function (count+1 times) on it; the result and {Z,N,C,V} are then
// offered on the response channel until the host takes them.
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   alu_cmd_sequencer_if.slave bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_func,
   input  logic [WIDTH-1:0] alu_y,
   input  logic [3:0]       alu_flags,
   output logic             busy
);

   seq_state_t       state_r;
   logic [WIDTH-1:0] acc_r;
   logic [3:0]       flags_r;
   logic [3:0]       func_r;
   logic [WIDTH-1:0] operand_r;
   logic [CNT_W-1:0] remaining_r;
   logic             cmd_ready_r;
   logic             rsp_valid_r;
   logic             busy_r;

   // Controller FSM with its datapath registers and registered handshake outputs.
   // cmd_ready is a register rather than a state decode so that it stays low
   // for the whole reset period and rises on the first clock after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         acc_r       <= {WIDTH{1'b0}};
         flags_r     <= 4'b0000;
         func_r      <= 4'b0000;
         operand_r   <= {WIDTH{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
         cmd_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_r) begin
                  func_r      <= bus.cmd_func;
                  operand_r   <= bus.cmd_operand;
                  remaining_r <= bus.cmd_count;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  state_r     <= bus.cmd_load ? LOAD : EXEC;
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            LOAD: begin
               acc_r           <= operand_r;
               flags_r[FLAG_Z] <= (operand_r == {WIDTH{1'b0}});
               flags_r[FLAG_N] <= operand_r[WIDTH-1];
               flags_r[FLAG_C] <= 1'b0;
               flags_r[FLAG_V] <= 1'b0;
               rsp_valid_r     <= 1'b1;
               state_r         <= RESP;
            end
            EXEC: begin
               acc_r           <= alu_y;
               flags_r[FLAG_Z] <= alu_flags[FLAG_Z];
               flags_r[FLAG_N] <= alu_flags[FLAG_N];
               // Logic and shift results leave the last arithmetic carry/overflow intact
               if (is_arith(func_r)) begin
                  flags_r[FLAG_C] <= alu_flags[FLAG_C];
                  flags_r[FLAG_V] <= alu_flags[FLAG_V];
               end
               if (remaining_r == {CNT_W{1'b0}}) begin
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end else begin
                  remaining_r <= remaining_r - CNT_W'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               cmd_ready_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   // The ALU always sees the accumulator and the latched operand/function;
   // its result is only consumed while in EXEC.
   assign alu_a         = acc_r;
   assign alu_b         = operand_r;
   assign alu_func      = func_r;

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_acc   = acc_r;
   assign bus.rsp_flags = flags_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
// Latency is counted in cycles from the cycle in which the command handshake
// is presented (cycle 0) to the first cycle rsp_valid is seen high.
module tb_alu_cmd_sequencer;
   import alu_cmd_sequencer_pkg::*;

   typedef struct {
      logic       load;
      logic [3:0] func;
      logic [3:0] operand;
      logic [2:0] count;
      logic [3:0] exp_acc;
      logic [3:0] exp_flags;
      int         exp_lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] alu_a, alu_b, alu_func, alu_y, alu_flags;
   logic       busy;
   logic [4:0] sum;
   logic       alu_c, alu_v;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs[18];

   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

   alu_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_func  (alu_func),
      .alu_y     (alu_y),
      .alu_flags (alu_flags),
      .busy      (busy)
   );

   // Behavioural ALU: shifts move one place, SUB carry means "no borrow",
   // unknown codes pass A; logic/shift ops give C from the shifted-out bit or 0.
   always_comb begin
      sum   = 5'd0;
      alu_y = alu_a;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_func)
         F_ADD: begin
            sum   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_y = sum[3:0];
            alu_c = sum[4];
            alu_v = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
         end
         F_SUB: begin
            sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            alu_y = sum[3:0];
            alu_c = sum[4];
            alu_v = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
         end
         F_AND:  alu_y = alu_a & alu_b;
         F_OR:   alu_y = alu_a | alu_b;
         F_XOR:  alu_y = alu_a ^ alu_b;
         F_SLL:  begin alu_y = {alu_a[2:0], 1'b0};   alu_c = alu_a[3]; end
         F_SRL:  begin alu_y = {1'b0, alu_a[3:1]};   alu_c = alu_a[0]; end
         F_SRA:  begin alu_y = {alu_a[3], alu_a[3:1]}; alu_c = alu_a[0]; end
         F_PASS: alu_y = alu_b;
         default: alu_y = alu_a;
      endcase
      alu_flags = {(alu_y == 4'd0), alu_y[3], alu_c, alu_v};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one command, scramble the command inputs while busy, then take the response
   task automatic run_cmd(input vec_t v, input int idx);
      int cycles;
      bit got;
      @(negedge clk);
      check($sformatf("v%0d ready_before", idx), {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_load    = v.load;
      bus.cmd_func    = v.func;
      bus.cmd_operand = v.operand;
      bus.cmd_count   = v.count;
      cycles = 0;
      got    = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            bus.cmd_load    = ~v.load;
            bus.cmd_func    = ~v.func;
            bus.cmd_operand = ~v.operand;
            bus.cmd_count   = ~v.count;
            check($sformatf("v%0d ready_busy", idx), {31'd0, bus.cmd_ready}, 32'd0);
         end
         if (bus.rsp_valid) got = 1'b1;
      end
      check($sformatf("v%0d latency", idx), cycles, v.exp_lat);
      check($sformatf("v%0d acc", idx), {28'd0, bus.rsp_acc}, {28'd0, v.exp_acc});
      check($sformatf("v%0d flags", idx), {28'd0, bus.rsp_flags}, {28'd0, v.exp_flags});
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check($sformatf("v%0d rsp_cleared", idx), {31'd0, bus.rsp_valid}, 32'd0);
      check($sformatf("v%0d ready_after", idx), {31'd0, bus.cmd_ready}, 32'd1);
   endtask

   initial begin
      bit bad;
      bit got;
      int cycles;

      // load, func, operand, count, exp_acc, exp_flags{Z,N,C,V}, latency
      vecs[0]  = '{1'b1, F_ADD,   4'd3,  3'd0, 4'd3,  4'b0000, 2};
      vecs[1]  = '{1'b0, F_ADD,   4'd2,  3'd2, 4'd9,  4'b0101, 4};
      vecs[2]  = '{1'b0, F_SUB,   4'd9,  3'd0, 4'd0,  4'b1010, 2};
      vecs[3]  = '{1'b0, F_XOR,   4'd5,  3'd0, 4'd5,  4'b0010, 2};
      vecs[4]  = '{1'b1, F_ADD,   4'd1,  3'd0, 4'd1,  4'b0000, 2};
      vecs[5]  = '{1'b0, F_SLL,   4'd1,  3'd2, 4'd8,  4'b0100, 4};
      vecs[6]  = '{1'b1, F_ADD,   4'd8,  3'd0, 4'd8,  4'b0100, 2};
      vecs[7]  = '{1'b0, F_SLL,   4'd1,  3'd0, 4'd0,  4'b1000, 2};
      vecs[8]  = '{1'b1, F_ADD,   4'd7,  3'd0, 4'd7,  4'b0000, 2};
      vecs[9]  = '{1'b0, F_ADD,   4'd1,  3'd7, 4'd15, 4'b0100, 9};
      vecs[10] = '{1'b0, F_SUB,   4'd1,  3'd0, 4'd14, 4'b0110, 2};
      vecs[11] = '{1'b0, 4'b0011, 4'd0,  3'd1, 4'd14, 4'b0110, 3};
      vecs[12] = '{1'b0, F_AND,   4'd3,  3'd0, 4'd2,  4'b0010, 2};
      vecs[13] = '{1'b0, F_OR,    4'd8,  3'd0, 4'd10, 4'b0110, 2};
      vecs[14] = '{1'b0, F_SRL,   4'd1,  3'd0, 4'd5,  4'b0010, 2};
      vecs[15] = '{1'b0, F_SRA,   4'd1,  3'd1, 4'd1,  4'b0010, 3};
      vecs[16] = '{1'b0, F_SUB,   4'd3,  3'd0, 4'd14, 4'b0100, 2};
      vecs[17] = '{1'b0, F_ADD,   4'd2,  3'd0, 4'd0,  4'b1010, 2};

      reset           = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_load    = 1'b0;
      bus.cmd_func    = 4'd0;
      bus.cmd_operand = 4'd0;
      bus.cmd_count   = 3'd0;
      bus.rsp_ready   = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst acc", {28'd0, bus.rsp_acc}, 32'd0);
      check("rst flags", {28'd0, bus.rsp_flags}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

      for (int i = 0; i < 18; i++) run_cmd(vecs[i], i);

      // Response backpressure with a competing command held on the bus
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_load    = 1'b1;
      bus.cmd_operand = 4'd5;
      bus.cmd_count   = 3'd0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (i == 0) bus.cmd_operand = 4'd12;
         if (bus.rsp_valid) got = 1'b1;
      end
      check("bp rsp_seen", {31'd0, got}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp%0d rsp_valid", i), {31'd0, bus.rsp_valid}, 32'd1);
         check($sformatf("bp%0d acc", i), {28'd0, bus.rsp_acc}, 32'd5);
         check($sformatf("bp%0d flags", i), {28'd0, bus.rsp_flags}, 32'd0);
         check($sformatf("bp%0d cmd_ready", i), {31'd0, bus.cmd_ready}, 32'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("bp acc_kept", {28'd0, alu_a}, 32'd5);
      check("bp busy", {31'd0, busy}, 32'd0);
      check("bp cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

      // Reset during the second iteration of an 8-iteration ADD
      bus.cmd_valid   = 1'b1;
      bus.cmd_load    = 1'b0;
      bus.cmd_func    = F_ADD;
      bus.cmd_operand = 4'd1;
      bus.cmd_count   = 3'd7;
      cycles = 0;
      repeat (2) begin
         @(negedge clk);
         cycles++;
         bus.cmd_valid = 1'b0;
      end
      check("mid busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid busy", {31'd0, busy}, 32'd0);
      check("mid acc", {28'd0, alu_a}, 32'd0);
      check("mid flags", {28'd0, bus.rsp_flags}, 32'd0);
      check("mid rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("mid cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) bad = 1'b1;
      end
      check("mid no_rsp", {31'd0, bad}, 32'd0);
      check("mid ready_after", {31'd0, bus.cmd_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-driven controller that sequences the 4-bit combinational ALU as an accumulator machine. It accepts commands over a valid/ready interface, each with a function code, a B operand and a repeat count. It drives the ALU's A, B and function inputs and iterates the operation on an internal accumulator. It then returns the accumulator and the latched Z/N/C/V flags over a valid/ready response interface. The ALU itself stays external; this block sits between the host/switch logic and the ALU.

Parameters:
WIDTH, 4, datapath width of accumulator, operand and ALU ports
CNT_W, 3, width of repeat-count field; max iterations = 2**CNT_W

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_load  input  1  1 = load cmd_operand into accumulator, no ALU use
cmd_func  input  4  ALU function code
cmd_operand  input  WIDTH  B operand, or load value
cmd_count  input  CNT_W  iterations minus one
alu_a  output  WIDTH  ALU A input (= accumulator)
alu_b  output  WIDTH  ALU B input (= latched operand)
alu_func  output  4  ALU function (= latched func)
alu_y  input  WIDTH  ALU result
alu_flags  input  4  ALU flags {Z,N,C,V}
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_acc  output  WIDTH  accumulator value
rsp_flags  output  4  flag register {Z,N,C,V}
busy  output  1  state != IDLE

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, ports named clk and reset.
- States: IDLE, EXEC, LOAD, RESP. A registered state drives all outputs.
- Reset applies on the clock edge:
  - state=IDLE; acc=0; flags=0; latched func/operand/remaining=0.
  - cmd_ready=0 and rsp_valid=0 while reset is high.
  - After reset, cmd_ready=1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch func, operand and remaining=cmd_count.
  - Next state is LOAD if cmd_load=1, else EXEC.
- LOAD (1 cycle):
  - acc<=operand.
  - Z<=(operand==0); N<=operand[WIDTH-1]; C<=0; V<=0.
  - Next state RESP.
- EXEC (one cycle per iteration):
  - acc<=alu_y.
  - Z,N<=alu_flags every iteration.
  - C,V<=alu_flags only when func is 0000 (add) or 0001 (sub); otherwise C,V hold.
  - If remaining==0, next state RESP; else remaining<=remaining-1 and stay in EXEC.
  - Count k gives exactly k+1 EXEC cycles, so rsp_valid rises k+2 cycles after the accept edge.
- Unsupported func codes are executed anyway. The ALU passes A, so acc is unchanged; Z,N are refreshed and C,V hold.
- alu_a/alu_b/alu_func are driven continuously from acc/operand/func. In IDLE they show the last values, and the ALU result is ignored outside EXEC.
- RESP:
  - rsp_valid=1; rsp_acc=acc and rsp_flags=flags, both stable until handshake.
  - On rsp_ready, return to IDLE.
  - cmd_ready=0 in RESP, so a new command is accepted no earlier than the cycle after the response handshake.
- Accumulator and flags persist across commands. Only reset or a LOAD command changes them outside EXEC.
- Arithmetic is mod 2**WIDTH; wrap-around is reported only via the ALU's C/V.
- cmd_count at its maximum (all ones) gives 2**CNT_W iterations, with no overflow of remaining.
- Reset mid-EXEC or mid-RESP aborts the command: the pending response is dropped and acc/flags clear.
- cmd_valid while busy is ignored. Command inputs are sampled only on the accept edge, so later changes have no effect.

Decomposition:
- Shared package holds:
  - ALU function constants F_ADD=0000, F_SUB=0001, F_AND=0100, F_OR=0101, F_XOR=0110, F_SLL=1000, F_SRL=1001, F_SRA=1010, F_PASS=1111.
  - State enum {IDLE, EXEC, LOAD, RESP}.
  - Flag bit indices Z=3, N=2, C=1, V=0.
- No sub-module: a single FSM plus registers. The bench instantiates the existing ALU alongside the block.

Test Plan:
- Reset, then LOAD operand=3 -> rsp_acc=3, flags=0000; the rsp_valid handshake returns the block to IDLE and cmd_ready=1.
- After acc=3: ADD B=2, count=2 -> EXEC runs 3 cycles (5,7,9); rsp_acc=9 with Z=0, N=1, C=0, V=1; rsp_valid rises 4 cycles after the accept edge.
- After acc=9: SUB B=9, count=0 -> rsp_acc=0, Z=1, N=0, C=1, V=0.
- LOAD 1 (C,V cleared), then SLL count=2 -> rsp_acc=8, Z=0, N=1, C=V=0 held; separately, with C=1 from a prior SUB, XOR keeps C=1.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_valid, rsp_acc and rsp_flags stay stable, cmd_ready=0, and no second command is accepted.
- Assert reset during iteration 2 of ADD count=7 -> next cycle IDLE, acc=0, flags=0, rsp_valid=0, and no response is issued.
